// File: rtl/mem_stage.sv
// Memory-access stage: issues data-memory loads/stores over a req/ack handshake,
// stalls upstream while an access is in flight, and registers the writeback slot.
module mem_stage #(
  parameter int BIT_WIDTH  = 32,
  parameter int REG_ADDR_W = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inValid,
  input  logic                  regWrEn,
  input  logic                  memWrEn,
  input  logic [1:0]            mulSel,
  input  logic [BIT_WIDTH-1:0]  aluOut,
  input  logic [BIT_WIDTH-1:0]  PC,
  input  logic [BIT_WIDTH-1:0]  storeData,
  input  logic [REG_ADDR_W-1:0] regWrAddr,
  output logic                  stall,
  output logic                  dmemReq,
  output logic                  dmemWe,
  output logic [BIT_WIDTH-1:0]  dmemAddr,
  output logic [BIT_WIDTH-1:0]  dmemWData,
  input  logic                  dmemAck,
  input  logic [BIT_WIDTH-1:0]  dmemRData,
  output logic                  wbValid,
  output logic                  wbRegWrEn,
  output logic [REG_ADDR_W-1:0] wbRegWrAddr,
  output logic [BIT_WIDTH-1:0]  wbData,
  output logic                  memFault
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [3:0] LAST_CNT = 4'(TIMEOUT - 1);

  state_t               state;
  logic [3:0]           waitCnt;
  logic                 pendRegWrEn;
  logic [BIT_WIDTH-1:0] pendAlu;
  logic                 memOp;

  function automatic logic [BIT_WIDTH-1:0] wbSelect(
    input logic [1:0]           sel,
    input logic [BIT_WIDTH-1:0] alu,
    input logic [BIT_WIDTH-1:0] pc,
    input logic [BIT_WIDTH-1:0] rdata
  );
    case (sel)
      2'b01:   wbSelect = rdata;
      2'b10:   wbSelect = pc;
      default: wbSelect = alu;
    endcase
  endfunction

  // A store with mulSel==01 is still only a store; memWrEn takes priority.
  assign memOp = inValid & (memWrEn | (mulSel == 2'b01));

  // Stall releases in the ack cycle so upstream advances on the completing edge.
  always_comb begin
    stall = 1'b0;
    if (reset) begin
      if (state == S_IDLE) stall = memOp;
      else                 stall = ~dmemAck;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      waitCnt     <= '0;
      pendRegWrEn <= 1'b0;
      pendAlu     <= '0;
      dmemReq     <= 1'b0;
      dmemWe      <= 1'b0;
      dmemAddr    <= '0;
      dmemWData   <= '0;
      wbValid     <= 1'b0;
      wbRegWrEn   <= 1'b0;
      wbRegWrAddr <= '0;
      wbData      <= '0;
      memFault    <= 1'b0;
    end else begin
      memFault <= 1'b0;
      case (state)
        S_IDLE: begin
          wbRegWrAddr <= regWrAddr;
          if (memOp) begin
            state       <= S_WAIT;
            waitCnt     <= '0;
            dmemReq     <= 1'b1;
            dmemWe      <= memWrEn;
            dmemAddr    <= {aluOut[BIT_WIDTH-1:2], 2'b00};
            dmemWData   <= storeData;
            pendAlu     <= aluOut;
            pendRegWrEn <= regWrEn;
            wbValid     <= 1'b0;
            wbRegWrEn   <= 1'b0;
          end else begin
            wbValid   <= inValid;
            wbRegWrEn <= inValid & regWrEn;
            wbData    <= wbSelect(mulSel, aluOut, PC, dmemRData);
          end
        end
        S_WAIT: begin
          if (dmemAck) begin
            state     <= S_IDLE;
            dmemReq   <= 1'b0;
            wbValid   <= 1'b1;
            wbRegWrEn <= pendRegWrEn;
            wbData    <= dmemWe ? pendAlu : dmemRData;
          end else if (waitCnt == LAST_CNT) begin
            // Abort: the slot is retired without a register write.
            state     <= S_IDLE;
            dmemReq   <= 1'b0;
            wbValid   <= 1'b1;
            wbRegWrEn <= 1'b0;
            memFault  <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random instruction mix, with a
// memory responder and a writeback scoreboard fed from a behavioural model.
module tb_mem_stage;
  localparam int BW = 32;
  localparam int RW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          inValid = 1'b0, regWrEn = 1'b0, memWrEn = 1'b0;
  logic [1:0]    mulSel = 2'b00;
  logic [BW-1:0] aluOut = '0, PC = '0, storeData = '0;
  logic [RW-1:0] regWrAddr = '0;
  logic          stall, dmemReq, dmemWe, dmemAck = 1'b0;
  logic [BW-1:0] dmemAddr, dmemWData, dmemRData = '0;
  logic          wbValid, wbRegWrEn, memFault;
  logic [RW-1:0] wbRegWrAddr;
  logic [BW-1:0] wbData;

  mem_stage #(.BIT_WIDTH(BW), .REG_ADDR_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .regWrEn(regWrEn), .memWrEn(memWrEn),
    .mulSel(mulSel), .aluOut(aluOut), .PC(PC), .storeData(storeData), .regWrAddr(regWrAddr),
    .stall(stall), .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
    .dmemWData(dmemWData), .dmemAck(dmemAck), .dmemRData(dmemRData), .wbValid(wbValid),
    .wbRegWrEn(wbRegWrEn), .wbRegWrAddr(wbRegWrAddr), .wbData(wbData), .memFault(memFault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          regWrEn;
    logic [RW-1:0] addr;
    logic [BW-1:0] data;
    logic          fault;
  } wb_t;

  typedef struct packed {
    logic [BW-1:0] addr;
    logic          we;
    logic [BW-1:0] wdata;
    logic [7:0]    delay;
  } req_t;

  wb_t     expWbQ[$];
  req_t    expReqQ[$];
  logic [BW-1:0] modelMem [16];
  logic [BW-1:0] respMem  [16];
  int      nTests = 0, nFail = 0;
  logic    strayAck = 1'b0;
  int      respCyc = 0, lastRise = 0, prevRise = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: acks the k-th WAIT cycle where k is the delay chosen at issue.
  initial begin : responder
    logic prevReq;
    int   idx, len, expLen;
    req_t cur;
    prevReq = 1'b0; idx = 0; len = 0; cur = '0;
    forever begin
      @(negedge clk);
      respCyc++;
      if (!reset) begin
        prevReq = 1'b0;
        dmemAck = 1'b0;
      end else begin
        if (dmemReq) begin
          if (!prevReq) begin
            prevRise = lastRise;
            lastRise = respCyc;
            chk("request expected", 32'(expReqQ.size() != 0), 32'd1);
            if (expReqQ.size() != 0) cur = expReqQ.pop_front();
            idx = 0;
          end else begin
            idx++;
          end
          chk("dmemAddr", dmemAddr, cur.addr);
          chk("dmemWe", 32'(dmemWe), 32'(cur.we));
          if (cur.we) chk("dmemWData", dmemWData, cur.wdata);
          dmemAck   = (idx == int'(cur.delay)) | strayAck;
          dmemRData = dmemAck ? respMem[dmemAddr[5:2]] : $urandom();
          if (dmemAck && dmemWe) respMem[dmemAddr[5:2]] = dmemWData;
          len = idx + 1;
        end else begin
          if (prevReq) begin
            expLen = (int'(cur.delay) < TO) ? int'(cur.delay) + 1 : TO;
            chk("dmemReq high cycles", 32'(len), 32'(expLen));
          end
          dmemAck   = strayAck;
          dmemRData = $urandom();
        end
        prevReq = dmemReq;
      end
    end
  end

  // Writeback monitor: pops one expectation per valid slot.
  initial begin : monitor
    wb_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (!wbValid) begin
          if (memFault) chk("memFault without wbValid", 32'(memFault), 32'd0);
          if (wbRegWrEn) chk("wbRegWrEn without wbValid", 32'(wbRegWrEn), 32'd0);
        end else begin
          chk("writeback expected", 32'(expWbQ.size() != 0), 32'd1);
          if (expWbQ.size() != 0) begin
            e = expWbQ.pop_front();
            chk("wbRegWrEn", 32'(wbRegWrEn), 32'(e.regWrEn));
            chk("memFault", 32'(memFault), 32'(e.fault));
            if (!e.fault) begin
              chk("wbData", wbData, e.data);
              chk("wbRegWrAddr", 32'(wbRegWrAddr), 32'(e.addr));
            end
          end
        end
      end
    end
  end

  // Presents one instruction at a negedge, holds it while stalled, returns at the
  // negedge where the next instruction may be presented.
  task automatic issue(input logic v, input logic rwe, input logic mwe, input logic [1:0] ms,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] sd,
                       input logic [3:0] rd, input int delay);
    logic isMem, isTo;
    int   expStall, cnt, w;
    wb_t  e;
    req_t r;
    isMem = v && (mwe || ms == 2'b01);
    isTo  = isMem && (delay >= TO);
    w     = int'(alu[5:2]);
    inValid = v; regWrEn = rwe; memWrEn = mwe; mulSel = ms;
    aluOut = alu; PC = pc; storeData = sd; regWrAddr = rd;
    expStall = 0;
    if (isMem) begin
      r.addr = {alu[31:2], 2'b00}; r.we = mwe; r.wdata = sd; r.delay = 8'(delay);
      expReqQ.push_back(r);
      e.addr = rd; e.fault = isTo; e.regWrEn = isTo ? 1'b0 : rwe;
      e.data = mwe ? alu : modelMem[w];
      if (mwe && !isTo) modelMem[w] = sd;
      expWbQ.push_back(e);
      expStall = isTo ? TO + 1 : delay + 1;
    end else if (v) begin
      e.addr = rd; e.fault = 1'b0; e.regWrEn = rwe;
      e.data = (ms == 2'b10) ? pc : alu;
      expWbQ.push_back(e);
    end
    #1;
    cnt = 0;
    while (stall && cnt < 60) begin
      cnt++;
      if (isTo && cnt == expStall) break;
      @(negedge clk);
      #1;
    end
    chk("stall cycles", 32'(cnt), 32'(expStall));
    @(negedge clk);
    if (isTo) inValid = 1'b0;
  endtask

  task automatic pulseStrayAck();
    #3 strayAck = 1'b1;
    @(negedge clk);
    #3 strayAck = 1'b0;
    @(negedge clk);
    #1;
    chk("dmemReq after stray ack", 32'(dmemReq), 32'd0);
    chk("memFault after stray ack", 32'(memFault), 32'd0);
    chk("wbValid after stray ack", 32'(wbValid), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int r, d;
    logic [1:0] ms;
    for (int i = 0; i < 16; i++) begin
      modelMem[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
      respMem[i]  = modelMem[i];
    end

    // Reset asserted mid-cycle with a memory op on the inputs.
    @(negedge clk);
    inValid = 1'b1; memWrEn = 1'b1; aluOut = 32'h44; regWrEn = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset dmemReq", 32'(dmemReq), 32'd0);
    chk("reset dmemWe", 32'(dmemWe), 32'd0);
    chk("reset dmemAddr", dmemAddr, 32'd0);
    chk("reset dmemWData", dmemWData, 32'd0);
    chk("reset wbValid", 32'(wbValid), 32'd0);
    chk("reset wbRegWrEn", 32'(wbRegWrEn), 32'd0);
    chk("reset wbRegWrAddr", 32'(wbRegWrAddr), 32'd0);
    chk("reset wbData", wbData, 32'd0);
    chk("reset memFault", 32'(memFault), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("stall held in reset", 32'(stall), 32'd0);
    chk("dmemReq held in reset", 32'(dmemReq), 32'd0);
    inValid = 1'b0; memWrEn = 1'b0; regWrEn = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);

    issue(1, 1, 0, 2'b00, 32'h0000_1234, 32'h0, 32'h0, 4'd3, 0);
    modelMem[0] = 32'hDEAD_BEEF; respMem[0] = 32'hDEAD_BEEF;
    issue(1, 1, 0, 2'b01, 32'h0000_0103, 32'h0, 32'h0, 4'd5, 3);
    issue(1, 0, 1, 2'b00, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 4'd7, 0);
    issue(1, 1, 0, 2'b01, 32'h0000_0040, 32'h0, 32'h0, 4'd8, 1);
    chk("back-to-back req interval", 32'(lastRise - prevRise), 32'd2);
    issue(1, 1, 0, 2'b01, 32'h0000_0008, 32'h0, 32'h0, 4'd9, 20);
    pulseStrayAck();
    issue(1, 1, 0, 2'b10, 32'h0000_5555, 32'h0000_0200, 32'h0, 4'd10, 0);
    issue(1, 1, 0, 2'b01, 32'h0000_0010, 32'h0, 32'h0, 4'd11, 14);
    issue(1, 1, 1, 2'b01, 32'h0000_0024, 32'h0, 32'h1357_9BDF, 4'd12, 2);

    // Reset during WAIT drops the access immediately.
    inValid = 1'b1; regWrEn = 1'b1; memWrEn = 1'b0; mulSel = 2'b01; aluOut = 32'h20;
    begin
      req_t rq;
      rq.addr = 32'h20; rq.we = 1'b0; rq.wdata = '0; rq.delay = 8'd200;
      expReqQ.push_back(rq);
    end
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid-access reset dmemReq", 32'(dmemReq), 32'd0);
    chk("mid-access reset stall", 32'(stall), 32'd0);
    chk("mid-access reset wbValid", 32'(wbValid), 32'd0);
    chk("mid-access reset dmemAddr", dmemAddr, 32'd0);
    @(negedge clk);
    #3 reset = 1'b1;
    pulseStrayAck();
    issue(1, 1, 0, 2'b11, 32'h0BAD_F00D, 32'h0, 32'h0, 4'd4, 0);

    for (int i = 0; i < 150; i++) begin
      r  = $urandom_range(0, 9);
      d  = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 4);
      ms = 2'($urandom_range(0, 3));
      if (r < 3)
        issue(1, 1'($urandom), 0, (ms == 2'b01) ? 2'b11 : ms, $urandom(), $urandom(), $urandom(),
              4'($urandom), 0);
      else if (r == 3)
        issue(0, 1'($urandom), 1'($urandom), ms, $urandom(), $urandom(), $urandom(), 4'($urandom), 0);
      else if (r < 7)
        issue(1, 1'($urandom), 0, 2'b01, 32'($urandom_range(0, 63)), $urandom(), $urandom(),
              4'($urandom), d);
      else
        issue(1, 1'($urandom), 1, ms, 32'($urandom_range(0, 63)), $urandom(), $urandom(),
              4'($urandom), d);
    end

    inValid = 1'b0;
    repeat (3) @(negedge clk);
    chk("writeback queue drained", 32'(expWbQ.size()), 32'd0);
    chk("request queue drained", 32'(expReqQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined processor. It sits directly downstream of the EX/MEM pipeline register and consumes its latched control and data: regWrEn, memWrEn, mulSel, aluOut, PC, plus store data and the destination register address. It performs loads and stores against the data memory over a req/ack handshake, stalling the pipeline while an access is outstanding. It selects the writeback value and registers it for the register file.

## Interface
- BIT_WIDTH, 32, datapath and address width
- REG_ADDR_W, 4, register-file address width
- TIMEOUT, 15, maximum cycles in WAIT before an access is aborted (1..15)

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- inValid  in  1  EX/MEM register holds a real instruction
- regWrEn  in  1  instruction writes the register file
- memWrEn  in  1  store
- mulSel  in  2  writeback select: 00 aluOut, 01 load data, 10 PC, 11 aluOut
- aluOut  in  BIT_WIDTH  ALU result / effective byte address
- PC  in  BIT_WIDTH  link value (already incremented)
- storeData  in  BIT_WIDTH  store data
- regWrAddr  in  REG_ADDR_W  destination register
- stall  out  1  upstream must hold EX/MEM (drives its buffWrEn low)
- dmemReq, dmemWe  out  1  access request / write strobe
- dmemAddr, dmemWData  out  BIT_WIDTH  word-aligned address ({aluOut[31:2],2'b00}) / store data
- dmemAck  in  1  access complete; read data valid this cycle
- dmemRData  in  BIT_WIDTH  load data
- wbValid, wbRegWrEn  out  1  writeback slot valid / register write enable
- wbRegWrAddr  out  REG_ADDR_W  writeback register
- wbData  out  BIT_WIDTH  writeback value
- memFault  out  1  one-cycle pulse: access timed out

## Operation
- Memory op: inValid & (memWrEn | mulSel==01). memWrEn has priority: a store with mulSel==01 does not read, and its wbData is aluOut.
- FSM states are IDLE and WAIT.
- IDLE, no memory op:
  - Writeback registers load at the edge: wbValid=inValid, wbRegWrEn=inValid&regWrEn, wbData per mulSel.
  - stall=0.
- IDLE, memory op:
  - stall=1 combinationally.
  - At the edge: latch dmemAddr, dmemWData, dmemWe=memWrEn, dmemReq=1, and the writeback control; clear the timeout counter; go to WAIT.
  - wbValid=0 at that edge (bubble).
- WAIT:
  - stall=1 and dmemReq=1. Address, data and we are stable until the access ends.
  - Counter increments each cycle without ack.
- WAIT and dmemAck:
  - At the edge: wbValid=1, wbData=dmemRData for a load or the latched aluOut for a store; dmemReq=0.
  - Go to IDLE. stall drops in that same cycle (combinationally, on ack).
- WAIT with counter==TIMEOUT-1 and no ack:
  - At the edge: abort; dmemReq=0; memFault=1 for one cycle; wbValid=1 with wbRegWrEn=0.
  - Go to IDLE.
- Ack arriving in the same cycle as the timeout: ack wins.
- dmemAck in IDLE: ignored.
- A late ack after a timeout: ignored.
- Reset asserted at any time: all outputs and state go to 0/IDLE immediately; an in-flight access is dropped and dmemReq falls asynchronously.

## Timing
- Reset values: stall 0, dmemReq 0, dmemWe 0, dmemAddr 0, dmemWData 0, wbValid 0, wbRegWrEn 0, wbRegWrAddr 0, wbData 0, memFault 0.
- Non-memory latency: 1 cycle, no stall.
- Memory op presented in cycle n:
  - dmemReq rises in cycle n+1.
  - Minimum completion is ack in n+1, with writeback visible in n+2.
  - stall is high in cycles n through the ack cycle inclusive.
- Back-to-back memory ops: the next op is sampled in the cycle after ack, giving a minimum issue interval of 2 cycles.
- Timeout: with no ack, dmemReq is high for exactly TIMEOUT cycles, and memFault is high in the following cycle.

## Test plan
- Reset then ALU op: assert reset low mid-cycle; all outputs 0. Then ALU op with aluOut=0x0000_1234, regWrAddr=3, mulSel=00 -> next cycle wbValid=1, wbRegWrEn=1, wbData=0x1234, wbRegWrAddr=3, stall never high.
- Load, ack after 3 cycles:
  - Stimulus: aluOut=0x0000_0103, mulSel=01, dmemRData=0xDEAD_BEEF.
  - Response: dmemAddr=0x100, dmemWe=0, stall high 4 cycles, wbData=0xDEADBEEF.
- Store followed by back-to-back load:
  - Stimulus: store storeData=0xCAFE_F00D to 0x40 with ack in the first WAIT cycle, then the load.
  - Response: dmemWe=1, dmemWData=0xCAFEF00D, store wbRegWrEn=0; the load's dmemReq rises 2 cycles after the store's rose.
- Timeout: load with dmemAck never asserted -> dmemReq high 15 cycles, memFault pulses once, wbValid=1 with wbRegWrEn=0. A subsequent stray ack has no effect.
- Link and ack/timeout collision:
  - Link: mulSel=10, PC=0x0000_0200 -> wbData=0x200.
  - Collision: ack on the 15th WAIT cycle -> normal completion, memFault stays 0.
- Reset mid-access: assert reset while in WAIT -> dmemReq and stall go 0 immediately. After release, an ack is ignored and the next ALU op completes normally.
